// File: rtl/decod38_pkg.sv
// Shared definitions for the 3-to-8 decoder address sequencer.
package decod38_pkg;

  localparam int unsigned N_OUT = 8;
  localparam int unsigned SEL_W = $clog2(N_OUT);

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SelFirstUp = 3'd0;
  localparam logic [SEL_W-1:0] SelLastUp  = 3'd7;
  localparam logic [SEL_W-1:0] SelFirstDn = 3'd7;
  localparam logic [SEL_W-1:0] SelLastDn  = 3'd0;

  function automatic logic [SEL_W-1:0] first_code(input logic dir);
    return dir ? SelFirstDn : SelFirstUp;
  endfunction

  function automatic logic [SEL_W-1:0] last_code(input logic dir);
    return dir ? SelLastDn : SelLastUp;
  endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter: counts up each cycle, synchronous clear, tc when count equals limit.
module dwell_cnt #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + DWELL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/decod38_scan_seq.sv
// Address sequencer for the 3-to-8 decoder: steps sel through all codes with a
// programmable dwell, one pass or continuous, with registered en/busy/done/wrap.
module decod38_scan_seq
  import decod38_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_e             state_q;
  logic               dir_q;
  logic               one_shot_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               tc;
  logic               cnt_clr;
  logic [SEL_W-1:0]   sel_next;

  // Counter runs only in RUN and restarts on every step or abort.
  assign cnt_clr  = (state_q != StRun) || tc || stop;
  assign sel_next = dir_q ? sel - SEL_W'(1) : sel + SEL_W'(1);

  dwell_cnt #(
    .DWELL_W(DWELL_W)
  ) u_dwell_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .limit(dwell_q),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      dwell_q    <= '0;
      sel        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_q    <= StRun;
            dir_q      <= dir;
            one_shot_q <= one_shot;
            dwell_q    <= dwell;
            sel        <= first_code(dir);
            en         <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StRun: begin
          // stop outranks any coincident step, wrap or finish
          if (stop) begin
            state_q <= StIdle;
            en      <= 1'b0;
            busy    <= 1'b0;
          end else if (tc) begin
            if (sel == last_code(dir_q) && one_shot_q) begin
              state_q <= StIdle;
              en      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              sel  <= sel_next;
              wrap <= (sel == last_code(dir_q));
            end
          end
        end
        default: begin
          state_q <= StIdle;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
